// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready payload register with an optional skid entry,
// flush-to-bubble, stall hold, occupancy reporting and a saturating stall counter.
module pipe_stage_elastic #(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNTW      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNTW-1:0]  stall_cnt
);

    // Handshake: a beat moves on a side when valid & ready are both high at the
    // rising edge; valid never depends on ready, and stall/flush force in_ready low.
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [CNTW-1:0]  r_stall_cnt;

    logic w_accept;
    logic w_drain;
    logic w_cnt_max;

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on registered state plus stall/flush, never on out_ready.
            assign in_ready = !r_skid_valid & !stall & !flush;
        end else begin : g_noskid
            assign in_ready = (!r_main_valid | out_ready) & !stall & !flush;
        end
    endgenerate

    assign out_valid = r_main_valid & !stall;
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign stall_cnt = r_stall_cnt;

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign w_cnt_max = &r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= NOP_VALUE;
            r_skid_data  <= NOP_VALUE;
            r_stall_cnt  <= '0;
        end else begin
            if (stall && r_main_valid && !w_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end

            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_main_data  <= NOP_VALUE;
                r_skid_data  <= NOP_VALUE;
            end else if (!stall) begin
                if (w_drain) begin
                    // Skid entry refills main first; accept is impossible while skid is full.
                    if (r_skid_valid) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                        r_skid_data  <= NOP_VALUE;
                    end else if (w_accept) begin
                        r_main_data <= in_data;
                    end else begin
                        r_main_valid <= 1'b0;
                        r_main_data  <= NOP_VALUE;
                    end
                end else if (w_accept) begin
                    if (!r_main_valid) begin
                        r_main_data  <= in_data;
                        r_main_valid <= 1'b1;
                    end else begin
                        r_skid_data  <= in_data;
                        r_skid_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
